// File: rtl/mul_result_accumulator.sv
// ---------------------------------------------------------------------------
// mul_result_accumulator
//
// Sums groups of multiplier products. The first product of a group fixes the
// group length (a length of 0 counts as 1). Every later accepted product is
// added modulo 2^ACC_W. The finished sum is held on out_acc with out_valid
// until the consumer takes it. A sticky flag records any two's-complement
// overflow seen while the group was being summed.
//
// Ports
//   clk            : clock; all state changes on its rising edge
//   rst            : synchronous active-high reset
//   in_prod        : product from the upstream multiplier (PROD_W bits)
//   in_prod_signed : 1 = sign-extend in_prod, 0 = zero-extend (per product)
//   in_len         : products per group, sampled on the first product only
//   in_valid       : upstream product is valid
//   out_ready      : accumulator can take a product (IDLE / ACC)
//   out_acc        : group sum, forced to zero while out_valid = 0
//   out_ovf        : sticky signed overflow of the group, zero while idle
//   out_valid      : group sum available (SEND)
//   in_ready       : downstream consumer takes the sum
// ---------------------------------------------------------------------------
module mul_result_accumulator #(
   parameter int PROD_W = 64,
   parameter int ACC_W  = 72,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PROD_W-1:0] in_prod,
   input  logic              in_prod_signed,
   input  logic [LEN_W-1:0]  in_len,
   input  logic              in_valid,
   output logic              out_ready,
   output logic [ACC_W-1:0]  out_acc,
   output logic              out_ovf,
   output logic              out_valid,
   input  logic              in_ready
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACC  = 2'b01,
      SEND = 2'b10
   } state_t;

   state_t             state_reg, state_next;
   logic [ACC_W-1:0]   acc_reg,   acc_next;
   logic [LEN_W-1:0]   cnt_reg,   cnt_next;
   logic [LEN_W-1:0]   len_reg,   len_next;
   logic               ovf_reg,   ovf_next;

   logic [ACC_W-1:0]   ext_prod;
   logic [ACC_W-1:0]   sum_acc;
   logic               ovf_step;
   logic [LEN_W-1:0]   len_eff;
   logic [LEN_W-1:0]   cnt_inc;
   logic               get_hs;
   logic               send_hs;

   // Extend the product to accumulator width bit by bit. Bits above the
   // product width carry the sign bit only for signed products.
   genvar gi;
   generate
      for (gi = 0; gi < ACC_W; gi++) begin : g_ext
         if (gi < PROD_W) begin : g_low
            assign ext_prod[gi] = in_prod[gi];
         end else begin : g_high
            assign ext_prod[gi] = in_prod_signed & in_prod[PROD_W-1];
         end
      end
   endgenerate

   assign get_hs  = in_valid & out_ready;
   assign send_hs = out_valid & in_ready;

   assign sum_acc = acc_reg + ext_prod;
   // Two addends with the same sign producing a result of the other sign.
   assign ovf_step = (acc_reg[ACC_W-1] == ext_prod[ACC_W-1]) &&
                     (sum_acc[ACC_W-1] != acc_reg[ACC_W-1]);

   // A zero length would never terminate the group, so it is read as 1.
   assign len_eff = (in_len == '0) ? LEN_W'(1) : in_len;
   assign cnt_inc = cnt_reg + LEN_W'(1);

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      len_next   = len_reg;
      ovf_next   = ovf_reg;
      case (state_reg)
         IDLE: begin
            if (get_hs) begin
               acc_next   = ext_prod;
               len_next   = len_eff;
               cnt_next   = LEN_W'(1);
               ovf_next   = 1'b0;
               state_next = (len_eff == LEN_W'(1)) ? SEND : ACC;
            end
         end
         ACC: begin
            // Without a product everything holds; there is no timeout.
            if (get_hs) begin
               acc_next = sum_acc;
               cnt_next = cnt_inc;
               ovf_next = ovf_reg | ovf_step;
               if (cnt_inc == len_reg) begin
                  state_next = SEND;
               end
            end
         end
         SEND: begin
            if (send_hs) begin
               acc_next   = '0;
               cnt_next   = '0;
               ovf_next   = 1'b0;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         len_reg   <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_next;
         len_reg   <= len_next;
         ovf_reg   <= ovf_next;
      end
   end

   assign out_ready = (state_reg != SEND);
   assign out_valid = (state_reg == SEND);
   assign out_acc   = out_valid ? acc_reg : '0;
   assign out_ovf   = out_valid & ovf_reg;

endmodule

// File: tb/tb_mul_result_accumulator.sv
// ---------------------------------------------------------------------------
// tb_mul_result_accumulator
//
// Bench for mul_result_accumulator: a default-width instance for the group
// arithmetic and handshakes, and two narrow instances (8-bit and 7-bit
// accumulators over 7-bit products) for the signed overflow flag.
// ---------------------------------------------------------------------------
module tb_mul_result_accumulator;

   logic        clk = 1'b0;
   logic        rst;

   // default-width instance
   logic [63:0] in_prod;
   logic        in_prod_signed;
   logic [7:0]  in_len;
   logic        in_valid;
   logic        out_ready;
   logic [71:0] out_acc;
   logic        out_ovf;
   logic        out_valid;
   logic        in_ready;

   // narrow instances share their inputs
   logic [6:0]  o_prod;
   logic        o_sgn;
   logic [7:0]  o_len;
   logic        o_valid;
   logic        o_in_ready;
   logic        o8_ready, o8_ovf, o8_valid;
   logic [7:0]  o8_acc;
   logic        o7_ready, o7_ovf, o7_valid;
   logic [6:0]  o7_acc;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mul_result_accumulator #(.PROD_W(64), .ACC_W(72), .LEN_W(8)) u_dut (
      .clk(clk), .rst(rst), .in_prod(in_prod), .in_prod_signed(in_prod_signed),
      .in_len(in_len), .in_valid(in_valid), .out_ready(out_ready),
      .out_acc(out_acc), .out_ovf(out_ovf), .out_valid(out_valid),
      .in_ready(in_ready)
   );

   mul_result_accumulator #(.PROD_W(7), .ACC_W(8), .LEN_W(8)) u_ovf8 (
      .clk(clk), .rst(rst), .in_prod(o_prod), .in_prod_signed(o_sgn),
      .in_len(o_len), .in_valid(o_valid), .out_ready(o8_ready),
      .out_acc(o8_acc), .out_ovf(o8_ovf), .out_valid(o8_valid),
      .in_ready(o_in_ready)
   );

   mul_result_accumulator #(.PROD_W(7), .ACC_W(7), .LEN_W(8)) u_ovf7 (
      .clk(clk), .rst(rst), .in_prod(o_prod), .in_prod_signed(o_sgn),
      .in_len(o_len), .in_valid(o_valid), .out_ready(o7_ready),
      .out_acc(o7_acc), .out_ovf(o7_ovf), .out_valid(o7_valid),
      .in_ready(o_in_ready)
   );

   typedef struct {
      logic [7:0]       len;
      int               n;
      logic [7:0][63:0] p;
      logic [7:0]       s;
      logic [71:0]      exp_acc;
      logic             exp_ovf;
      int               hold;
   } vec_t;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic push(input logic [63:0] p, input logic s, input logic [7:0] len);
      in_prod = p; in_prod_signed = s; in_len = len; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Reference: sum of the products taken as integers (sign- or zero-extended),
   // reduced to 72 bits; overflow is any partial sum whose exact value leaves
   // the 72-bit signed range.
   function automatic void model(input int n, input logic [7:0][63:0] p, input logic [7:0] s,
                                 output logic [71:0] acc, output logic ovf);
      logic signed [73:0] wide, hi, lo, a, b;
      hi  = (74'sd1 <<< 71) - 74'sd1;
      lo  = -(74'sd1 <<< 71);
      acc = '0;
      ovf = 1'b0;
      for (int i = 0; i < n; i++) begin
         b = s[i] ? 74'($signed(p[i])) : $signed({10'd0, p[i]});
         if (i == 0) begin
            acc = b[71:0];
         end else begin
            a    = $signed({{2{acc[71]}}, acc});
            wide = a + $signed({{2{b[71]}}, b[71:0]});
            if (wide > hi || wide < lo) ovf = 1'b1;
            acc = wide[71:0];
         end
      end
   endfunction

   task automatic take_sum(input string name);
      in_ready = 1'b1;
      tick();
      in_ready = 1'b0;
      check({name, " idle valid"}, out_valid, 0);
      check({name, " idle acc"},   out_acc,   0);
      check({name, " idle ovf"},   out_ovf,   0);
      check({name, " idle ready"}, out_ready, 1);
   endtask

   task automatic do_group(input string name, input logic [7:0] len, input int n,
                           input logic [7:0][63:0] p, input logic [7:0] s,
                           input logic [71:0] exp_acc, input logic exp_ovf,
                           input bit gaps, input int hold);
      for (int i = 0; i < n; i++) begin
         if (gaps && i > 0) idle($urandom_range(0, 2));
         check({name, " ready"}, out_ready, 1);
         // in_len is scrambled after the first product; it must be ignored
         push(p[i], s[i], (i == 0) ? len : 8'($urandom));
      end
      check({name, " valid"}, out_valid, 1);
      check({name, " acc"},   out_acc,   exp_acc);
      check({name, " ovf"},   out_ovf,   exp_ovf);
      check({name, " ready"}, out_ready, 0);
      for (int h = 0; h < hold; h++) begin
         in_ready = 1'b0;
         tick();
         check({name, " hold acc"},   out_acc,   exp_acc);
         check({name, " hold valid"}, out_valid, 1);
         check({name, " hold ready"}, out_ready, 0);
      end
      take_sum(name);
   endtask

   task automatic ovf_group(input string name, input int n, input logic [2:0][6:0] p,
                            input logic sgn, input logic [7:0] e8, input logic v8,
                            input logic [6:0] e7, input logic v7);
      for (int i = 0; i < n; i++) begin
         o_prod = p[i]; o_sgn = sgn; o_len = 8'(n); o_valid = 1'b1;
         tick();
         o_valid = 1'b0;
      end
      check({name, " v8"},   o8_valid, 1);
      check({name, " v7"},   o7_valid, 1);
      check({name, " acc8"}, o8_acc,   e8);
      check({name, " ovf8"}, o8_ovf,   v8);
      check({name, " acc7"}, o7_acc,   e7);
      check({name, " ovf7"}, o7_ovf,   v7);
      o_in_ready = 1'b1;
      tick();
      o_in_ready = 1'b0;
      check({name, " done8"}, o8_valid, 0);
      check({name, " done7"}, o7_ovf,   0);
      check({name, " rdy8"},  o8_ready, 1);
      check({name, " rdy7"},  o7_ready, 1);
   endtask

   function automatic vec_t mk(input logic [7:0] len, input int n,
                               input logic [63:0] p0, input logic [63:0] p1,
                               input logic [63:0] p2, input logic [63:0] p3,
                               input logic [3:0] s, input logic [71:0] e,
                               input logic v, input int hold);
      vec_t r;
      r.len = len; r.n = n; r.p = '0;
      r.p[0] = p0; r.p[1] = p1; r.p[2] = p2; r.p[3] = p3;
      r.s = {4'b0, s}; r.exp_acc = e; r.exp_ovf = v; r.hold = hold;
      return r;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1);
   end

   initial begin
      vec_t             vecs[6];
      logic [7:0][63:0] rp;
      logic [7:0]       rs;
      logic [71:0]      m_acc;
      logic             m_ovf;
      logic [7:0]       rlen;
      int               rn;

      rst = 1'b1; in_prod = '0; in_prod_signed = 1'b0; in_len = '0; in_valid = 1'b0;
      in_ready = 1'b0; o_prod = '0; o_sgn = 1'b0; o_len = '0; o_valid = 1'b0;
      o_in_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      check("reset ready", out_ready, 1);
      check("reset valid", out_valid, 0);
      check("reset acc",   out_acc,   0);
      check("reset ovf",   out_ovf,   0);
      check("reset v8",    o8_valid,  0);

      // s bits: bit i = signedness of product i
      vecs[0] = mk(8'd3, 3, 64'd5, 64'd7, 64'd9, 64'd0, 4'b0000, 72'd21, 1'b0, 0);
      vecs[1] = mk(8'd2, 2, 64'hFFFF_FFFF_FFFF_FFFA, 64'd4, 64'd0, 64'd0, 4'b0011,
                   72'hFF_FFFF_FFFF_FFFF_FFFE, 1'b0, 0);
      vecs[2] = mk(8'd0, 1, 64'd13, 64'd0, 64'd0, 64'd0, 4'b0000, 72'd13, 1'b0, 0);
      vecs[3] = mk(8'd2, 2, 64'd100, 64'd23, 64'd0, 64'd0, 4'b0000, 72'd123, 1'b0, 5);
      vecs[4] = mk(8'd4, 4, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd2,
                   4'b1010, 72'h01_0000_0000_0000_0001, 1'b0, 1);
      vecs[5] = mk(8'd1, 1, 64'h8000_0000_0000_0000, 64'd0, 64'd0, 64'd0, 4'b0001,
                   72'hFF_8000_0000_0000_0000, 1'b0, 0);
      for (int i = 0; i < 6; i++) begin
         do_group($sformatf("vec%0d", i), vecs[i].len, vecs[i].n, vecs[i].p, vecs[i].s,
                  vecs[i].exp_acc, vecs[i].exp_ovf, 1'b0, vecs[i].hold);
      end

      // A product offered in the SEND cycle of the handshake is refused; it
      // is taken one cycle later as a new single-product group.
      push(64'd11, 1'b0, 8'd1);
      check("sendacc valid", out_valid, 1);
      in_prod = 64'd100; in_prod_signed = 1'b0; in_len = 8'd1; in_valid = 1'b1;
      in_ready = 1'b1;
      tick();
      in_ready = 1'b0;
      check("sendacc refused valid", out_valid, 0);
      check("sendacc refused acc",   out_acc,   0);
      check("sendacc ready",         out_ready, 1);
      tick();
      in_valid = 1'b0;
      check("sendacc next valid", out_valid, 1);
      check("sendacc next acc",   out_acc,   100);
      take_sum("sendacc");

      // Reset after 2 of 4 products, then a fresh single-product group.
      push(64'd10, 1'b0, 8'd4);
      push(64'd20, 1'b0, 8'd4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst valid", out_valid, 0);
      check("midrst ready", out_ready, 1);
      check("midrst acc",   out_acc,   0);
      rp = '0; rp[0] = 64'd3;
      do_group("midrst new", 8'd1, 1, rp, 8'd0, 72'd3, 1'b0, 1'b0, 0);

      // Reset while a sum is pending.
      push(64'd7, 1'b0, 8'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("sendrst valid", out_valid, 0);
      tick();
      check("sendrst stay", out_valid, 0);

      // Longest group the counter allows.
      for (int i = 0; i < 255; i++) begin
         if (i == 254) check("len255 early valid", out_valid, 0);
         push(64'd1, 1'b0, (i == 0) ? 8'd255 : 8'd0);
      end
      check("len255 valid", out_valid, 1);
      check("len255 acc",   out_acc,   255);
      take_sum("len255");

      // Narrow overflow cases; products listed as {p2, p1, p0}.
      ovf_group("ovf 3f+3f",    2, {7'h00, 7'h3F, 7'h3F}, 1'b1, 8'h7E, 1'b0, 7'h7E, 1'b1);
      ovf_group("ovf sticky",   3, {7'h7F, 7'h3F, 7'h3F}, 1'b1, 8'h7D, 1'b0, 7'h7D, 1'b1);
      ovf_group("ovf unsigned", 2, {7'h00, 7'h7F, 7'h7F}, 1'b0, 8'hFE, 1'b1, 7'h7E, 1'b0);
      ovf_group("ovf neg",      2, {7'h00, 7'h40, 7'h40}, 1'b1, 8'h80, 1'b0, 7'h00, 1'b1);

      // Random groups with gaps, scrambled in_len and random backpressure.
      for (int g = 0; g < 25; g++) begin
         rlen = 8'($urandom_range(0, 6));
         rn   = (rlen == 8'd0) ? 1 : int'(rlen);
         rp   = '0;
         rs   = '0;
         for (int i = 0; i < rn; i++) begin
            rp[i] = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) rp[i] = 64'($urandom_range(0, 1000));
            rs[i] = 1'($urandom_range(0, 1));
         end
         model(rn, rp, rs, m_acc, m_ovf);
         do_group($sformatf("rand%0d", g), rlen, rn, rp, rs, m_acc, m_ovf, 1'b1,
                  $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
